// File: rtl/display_pkg.sv
// Shared widths, scan-word layout and seven-segment code table for the display scanner.
package display_pkg;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 8;
    localparam int SCAN_W     = 12;
    localparam int SEL_LSB    = 8;
    localparam int IDX_W      = 2;

    // Segment codes, bit order g..a, active-high, indexed by hex value.
    localparam logic [6:0] SEG7_CODE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct packed {
        logic [NUM_DIGITS*DIGIT_W-1:0] digits;
        logic [NUM_DIGITS-1:0]         dp;
        logic [NUM_DIGITS-1:0]         blank;
    } disp_t;

endpackage

// File: rtl/display_scan_seg7_decoder.sv
// Combinational hex nibble to seven-segment (g..a) decoder.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] hex,
    output logic [6:0]         seg
);

    always_comb begin
        seg = SEG7_CODE[hex];
    end

endmodule

// File: rtl/display_scan.sv
// Four-digit seven-segment scan driver with frame-aligned double buffering.
// Emits {one-hot select, dp+segments} one cycle after the selected index.
module display_scan
    import display_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter int CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    input  logic [NUM_DIGITS-1:0]         dp,
    input  logic [NUM_DIGITS-1:0]         blank,
    output logic [SCAN_W-1:0]             scan_out,
    output logic                          frame_done
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    disp_t              pending;
    disp_t              shadow;
    disp_t              incoming;
    logic               pending_valid;
    logic               wrap_d;

    logic               tc;
    logic               wrap;
    logic [DIGIT_W-1:0] cur_digit;
    logic [6:0]         cur_seg;
    logic [SCAN_W-1:0]  scan_next;

    assign tc       = en && (cnt == CNT_TC);
    assign wrap     = tc && (idx == IDX_W'(NUM_DIGITS - 1));
    assign incoming = '{digits: digits, dp: dp, blank: blank};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (tc) begin
            cnt <= '0;
            idx <= idx + IDX_W'(1);
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // A load landing on the wrap edge bypasses pending so the next frame shows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending       <= '0;
            shadow        <= '0;
            pending_valid <= 1'b0;
        end else begin
            if (load && wrap) begin
                shadow        <= incoming;
                pending_valid <= 1'b0;
            end else if (load) begin
                pending       <= incoming;
                pending_valid <= 1'b1;
            end else if (wrap && pending_valid) begin
                shadow        <= pending;
                pending_valid <= 1'b0;
            end
        end
    end

    assign cur_digit = shadow.digits[{idx, 2'b00} +: DIGIT_W];

    seg7_decoder u_seg7_decoder (
        .hex (cur_digit),
        .seg (cur_seg)
    );

    always_comb begin
        scan_next = '0;
        scan_next[SCAN_W-1:SEL_LSB] = 4'b0001 << idx;
        if (!shadow.blank[idx]) begin
            scan_next[SEG_W-1:0] = {shadow.dp[idx], cur_seg};
        end
    end

    // frame_done is delayed twice so it lines up with digit 0 of the new frame on scan_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_out   <= '0;
            wrap_d     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            scan_out   <= en ? scan_next : '0;
            wrap_d     <= wrap;
            frame_done <= en && wrap_d;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench: two scanners (CLK_DIV=4 and CLK_DIV=1) against an arithmetic reference model.
module tb_display_scan;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [11:0] scan_o [2];
    logic        fd_o   [2];

    int n_cmp = 0;
    int n_bad = 0;

    display_scan #(.CLK_DIV(4), .CNT_W(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits(digits),
        .dp(dp), .blank(blank), .scan_out(scan_o[0]), .frame_done(fd_o[0])
    );

    display_scan #(.CLK_DIV(1), .CNT_W(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits(digits),
        .dp(dp), .blank(blank), .scan_out(scan_o[1]), .frame_done(fd_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int          mpos    [2];
    logic [15:0] sh_dig  [2];
    logic [3:0]  sh_dp   [2];
    logic [3:0]  sh_blk  [2];
    logic [15:0] pe_dig  [2];
    logic [3:0]  pe_dp   [2];
    logic [3:0]  pe_blk  [2];
    logic        pv      [2];
    logic        fdp     [2];
    logic [11:0] exp_scan[2];
    logic        exp_fd  [2];

    function automatic int div_of(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [11:0] word(int i, logic [15:0] d, logic [3:0] p, logic [3:0] b);
        logic [3:0] sel;
        logic [3:0] nib;
        sel = 4'(1 << i);
        nib = d[i*4 +: 4];
        if (b[i]) return {sel, 8'h00};
        return {sel, p[i], seg_tab[nib]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mpos[k] = 0; sh_dig[k] = '0; sh_dp[k] = '0; sh_blk[k] = '0;
                pe_dig[k] = '0; pe_dp[k] = '0; pe_blk[k] = '0; pv[k] = 1'b0;
                fdp[k] = 1'b0; exp_scan[k] = '0; exp_fd[k] = 1'b0;
            end else begin
                automatic int  d = div_of(k);
                automatic bit  wrapping = en && (mpos[k] == 4*d - 1);
                if (en) begin
                    exp_scan[k] = word(mpos[k] / d, sh_dig[k], sh_dp[k], sh_blk[k]);
                    exp_fd[k]   = fdp[k];
                    mpos[k]     = (mpos[k] + 1) % (4*d);
                end else begin
                    exp_scan[k] = '0;
                    exp_fd[k]   = 1'b0;
                end
                fdp[k] = wrapping;
                if (load && wrapping) begin
                    sh_dig[k] = digits; sh_dp[k] = dp; sh_blk[k] = blank; pv[k] = 1'b0;
                end else if (load) begin
                    pe_dig[k] = digits; pe_dp[k] = dp; pe_blk[k] = blank; pv[k] = 1'b1;
                end else if (wrapping && pv[k]) begin
                    sh_dig[k] = pe_dig[k]; sh_dp[k] = pe_dp[k]; sh_blk[k] = pe_blk[k]; pv[k] = 1'b0;
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1; en = 1'b0; load = 1'b0; digits = '0; dp = '0; blank = '0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (scan_o[k] !== 12'h000 || fd_o[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset dut%0d: scan=%h fd=%b, want 000 0", k, scan_o[k], fd_o[k]);
            end
        end
        rst_n = 1'b1; en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (scan_o[k] !== 12'h13F) begin
                n_bad++;
                $display("FAIL reset_first dut%0d: scan=%h, want 13F", k, scan_o[k]);
            end
        end
    endtask

    task automatic test_basic();
        logic [11:0] want [4] = '{12'h106, 12'h25B, 12'h44F, 12'h866};
        int guard = 0;
        digits = 16'h4321; dp = 4'h0; blank = 4'h0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (2) @(negedge clk);
        while (fd_o[0] !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        n_cmp++;
        if (guard >= 100) begin n_bad++; $display("FAIL basic_wait: no frame_done, want pulse"); end
        for (int c = 0; c < 33; c++) begin
            n_cmp++;
            if (c < 32 && scan_o[0] !== want[(c / 4) % 4]) begin
                n_bad++;
                $display("FAIL basic_seq c=%0d: scan=%h, want %h", c, scan_o[0], want[(c/4)%4]);
            end
            n_cmp++;
            if (fd_o[0] !== (c % 16 == 0)) begin
                n_bad++;
                $display("FAIL basic_fd c=%0d: fd=%b, want %b", c, fd_o[0], (c % 16 == 0));
            end
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (scan_o[k] !== exp_scan[k] || fd_o[k] !== exp_fd[k]) begin
                    n_bad++;
                    $display("FAIL basic_model dut%0d: scan=%h fd=%b, want %h %b", k, scan_o[k], fd_o[k], exp_scan[k], exp_fd[k]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_midframe();
        int guard = 0;
        while (mpos[0] / 4 != 1 && guard < 32) begin @(negedge clk); guard++; end
        digits = 16'hFEDC; load = 1'b1;
        @(negedge clk); load = 1'b0;
        guard = 0;
        while (fd_o[0] !== 1'b1 && guard < 40) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (scan_o[k] !== exp_scan[k] || fd_o[k] !== exp_fd[k]) begin
                    n_bad++;
                    $display("FAIL midframe_model dut%0d: scan=%h fd=%b, want %h %b", k, scan_o[k], fd_o[k], exp_scan[k], exp_fd[k]);
                end
            end
            n_cmp++;
            if (k_is_new(scan_o[0])) begin
                n_bad++;
                $display("FAIL midframe_torn: scan=%h shows new data, want old frame", scan_o[0]);
            end
            @(negedge clk); guard++;
        end
        n_cmp++;
        if (scan_o[0] !== 12'h139) begin
            n_bad++;
            $display("FAIL midframe_next: scan=%h, want 139", scan_o[0]);
        end
    endtask

    function automatic bit k_is_new(logic [11:0] s);
        return s == 12'h139 || s == 12'h25E || s == 12'h479 || s == 12'h871;
    endfunction

    task automatic test_blank_dp();
        logic [11:0] want [4] = '{12'h1FF, 12'h27F, 12'h400, 12'h87F};
        int guard = 0;
        digits = 16'h8888; dp = 4'b0001; blank = 4'b0100; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (2) @(negedge clk);
        while (fd_o[0] !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        for (int c = 0; c < 16; c++) begin
            n_cmp++;
            if (scan_o[0] !== want[c / 4]) begin
                n_bad++;
                $display("FAIL blank_dp c=%0d: scan=%h, want %h", c, scan_o[0], want[c/4]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_enable();
        int guard = 0;
        while (mpos[0] / 4 != 2 && guard < 32) begin @(negedge clk); guard++; end
        en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (scan_o[k] !== 12'h000 || fd_o[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL en_low dut%0d: scan=%h fd=%b, want 000 0", k, scan_o[k], fd_o[k]);
                end
            end
        end
        en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (scan_o[0][11:8] !== 4'b0100) begin
            n_bad++;
            $display("FAIL en_resume: sel=%b, want 0100", scan_o[0][11:8]);
        end
        repeat (20) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (scan_o[k] !== exp_scan[k] || fd_o[k] !== exp_fd[k]) begin
                    n_bad++;
                    $display("FAIL en_model dut%0d: scan=%h fd=%b, want %h %b", k, scan_o[k], fd_o[k], exp_scan[k], exp_fd[k]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clkdiv1();
        logic [3:0] want_sel [3] = '{4'b0010, 4'b0100, 4'b1000};
        int guard = 0;
        while (mpos[1] != 3 && guard < 8) begin @(negedge clk); guard++; end
        digits = 16'h0A5B; dp = 4'h0; blank = 4'h0; load = 1'b1;
        @(negedge clk); load = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (scan_o[1] !== 12'h17C || fd_o[1] !== 1'b1) begin
            n_bad++;
            $display("FAIL div1_wrap_load: scan=%h fd=%b, want 17C 1", scan_o[1], fd_o[1]);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (scan_o[1][11:8] !== want_sel[c]) begin
                n_bad++;
                $display("FAIL div1_rotate c=%0d: sel=%b, want %b", c, scan_o[1][11:8], want_sel[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (scan_o[k] !== exp_scan[k] || fd_o[k] !== exp_fd[k]) begin
                    n_bad++;
                    $display("FAIL random c=%0d dut%0d: scan=%h fd=%b, want %h %b", c, k, scan_o[k], fd_o[k], exp_scan[k], exp_fd[k]);
                end
            end
            en     = ($urandom_range(0, 9) != 0);
            load   = ($urandom_range(0, 5) == 0);
            digits = 16'($urandom);
            dp     = 4'($urandom);
            blank  = 4'($urandom);
            @(negedge clk);
        end
        en = 1'b1; load = 1'b0;
    endtask

    task automatic test_async_reset();
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (scan_o[k] !== 12'h000 || fd_o[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL async_reset dut%0d: scan=%h fd=%b, want 000 0", k, scan_o[k], fd_o[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (scan_o[k] !== 12'h13F || fd_o[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL post_reset dut%0d: scan=%h fd=%b, want 13F 0", k, scan_o[k], fd_o[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_midframe();
        test_blank_dp();
        test_enable();
        test_clkdiv1();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
